// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// The master supplies operands and accepts results; the slave is the divider.
interface seq_divider_if #(
  parameter int unsigned W = 128
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         dbz;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Q, R, dbz
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Q, R, dbz
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero bypasses the iteration: Q=all ones, R=A, dbz=1.
module seq_divider #(
  parameter int unsigned W = 128
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  q;
  logic [W-1:0]  dvs;
  logic [W-1:0]  rem;
  logic [CW-1:0] cnt;
  logic          dbz_r;
  logic          accept;
  logic          take;
  logic [W:0]    rem_sh;
  logic [W:0]    rem_sub;

  // rem < dvs always holds, so the stored remainder needs only W bits. Because
  // rem_sh < 2*dvs, bit W of the W+1-bit difference is exactly the borrow.
  always_comb begin
    rem_sh  = {rem, q[W-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    take    = ~rem_sub[W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = (bus.B == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      dbz_r <= 1'b0;
    end else if (accept) begin
      dvs <= bus.B;
      cnt <= CW'(W);
      if (bus.B == '0) begin
        q     <= '1;
        rem   <= bus.A;
        dbz_r <= 1'b1;
      end else begin
        q     <= bus.A;
        rem   <= '0;
        dbz_r <= 1'b0;
      end
    end else if (state == CALC) begin
      q   <= {q[W-2:0], take};
      rem <= take ? rem_sub[W-1:0] : rem_sh[W-1:0];
      cnt <= cnt - CW'(1);
    end
  end

  assign bus.Q   = q;
  assign bus.R   = rem;
  assign bus.dbz = dbz_r;
endmodule
